// File: rtl/nv_ram_rwsp_fifo_ctrl_160x16.sv
// FIFO controller for a 160x16 two-port registered-output RAM: writes pushes into the RAM,
// prefetches through the 2-cycle read path into a small skid buffer, and serves pops from it.
module nv_ram_rwsp_fifo_ctrl_160x16 #(
    parameter int DEPTH      = 160,
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int SKID_DEPTH = 4
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pwrbus_pd
);

    localparam int RCW = $clog2(DEPTH + 1);
    localparam int SW  = $clog2(SKID_DEPTH);
    localparam int CW  = $clog2(SKID_DEPTH + 1);

    logic           rdy_en;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [RCW-1:0] ram_cnt;
    logic           s1_vld, s2_vld;
    logic [SW-1:0]  skid_head, skid_tail;
    logic [CW-1:0]  skid_cnt;
    logic [DW-1:0]  skid_mem [SKID_DEPTH];

    logic           push, pop, issue, capture;
    logic [CW:0]    in_flight;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [SW-1:0] skid_inc(input logic [SW-1:0] p);
        return (p == SW'(SKID_DEPTH - 1)) ? '0 : p + SW'(1);
    endfunction

    // NOTE: every signal driven here gets a value before any condition, so no latch can be inferred.
    always_comb begin
        wr_prdy   = 1'b0;
        wr_prdy   = rdy_en && (ram_cnt < RCW'(DEPTH));
        push      = wr_pvld && wr_prdy;
        rd_pvld   = (skid_cnt != '0);
        pop       = rd_pvld && rd_prdy;
        capture   = s2_vld;
        // Credits cover every entry already headed for the skid; a pop this cycle frees one.
        in_flight = (CW+1)'(s1_vld) + (CW+1)'(s2_vld) + (CW+1)'(skid_cnt);
        issue     = (ram_cnt != '0) && (in_flight < ((CW+1)'(SKID_DEPTH) + (CW+1)'(pop)));
    end

    assign ram_we        = push;
    assign ram_wa        = wr_ptr;
    assign ram_di        = wr_pd;
    assign ram_re        = issue;
    assign ram_ra        = rd_ptr;
    assign ram_ore       = s1_vld;
    assign rd_pd         = skid_mem[skid_head];
    assign ram_pwrbus_pd = pwrbus_ram_pd;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rdy_en    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            skid_head <= '0;
            skid_tail <= '0;
            skid_cnt  <= '0;
        end else begin
            rdy_en <= 1'b1;
            s1_vld <= issue;
            s2_vld <= s1_vld;
            if (push)    wr_ptr    <= ptr_inc(wr_ptr);
            if (issue)   rd_ptr    <= ptr_inc(rd_ptr);
            if (pop)     skid_head <= skid_inc(skid_head);
            if (capture) skid_tail <= skid_inc(skid_tail);
            case ({push, issue})
                2'b10:   ram_cnt <= ram_cnt + RCW'(1);
                2'b01:   ram_cnt <= ram_cnt - RCW'(1);
                default: ram_cnt <= ram_cnt;
            endcase
            case ({capture, pop})
                2'b10:   skid_cnt <= skid_cnt + CW'(1);
                2'b01:   skid_cnt <= skid_cnt - CW'(1);
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    // NOTE: skid storage has no reset; skid_cnt gates rd_pvld, so stale words are never presented.
    always_ff @(posedge nvdla_core_clk) begin
        if (capture) skid_mem[skid_tail] <= ram_dout;
    end

    skid_overflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !(capture && !pop && (skid_cnt == CW'(SKID_DEPTH))));

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl_160x16.sv
// Self-checking bench: behavioural RAM model, queue scoreboard with decoupled monitors,
// directed latency/full/reset scenarios and randomized traffic.
module tb_nv_ram_rwsp_fifo_ctrl_160x16;

    localparam int DEPTH = 160;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int TOTAL = 164;

    logic          nvdla_core_clk = 1'b0;
    logic          nvdla_core_rstn = 1'b0;
    logic          wr_pvld = 1'b0, wr_prdy;
    logic [DW-1:0] wr_pd = '0;
    logic          rd_pvld, rd_prdy = 1'b0;
    logic [DW-1:0] rd_pd;
    logic [AW-1:0] ram_wa, ram_ra;
    logic          ram_we, ram_re, ram_ore;
    logic [DW-1:0] ram_di, ram_dout;
    logic [31:0]   pwrbus_ram_pd = 32'hDEADBEEF, ram_pwrbus_pd;

    nv_ram_rwsp_fifo_ctrl_160x16 dut (
        .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
        .pwrbus_ram_pd(pwrbus_ram_pd), .ram_pwrbus_pd(ram_pwrbus_pd)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Two-port RAM with registered output: address latched on re, data registered on ore.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_q;
    logic [DW-1:0] dout_q;
    always @(posedge nvdla_core_clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_q <= ram_ra;
        if (ram_ore) dout_q <= mem[ra_q];
    end
    assign ram_dout = dout_q;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q [$];
    int last_wa = DEPTH - 1, last_ra = DEPTH - 1;
    int wa_wraps = 0, ra_wraps = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    // Stimulus side of the scoreboard: every accepted push becomes an expected output.
    always @(negedge nvdla_core_clk) begin
        if (nvdla_core_rstn && wr_pvld && wr_prdy) begin
            exp_q.push_back(wr_pd);
            check("occupancy_le_164", 32'(exp_q.size() <= TOTAL), 1);
        end
    end

    // Output side: compare each popped word against the oldest expected one.
    always @(negedge nvdla_core_clk) begin
        if (nvdla_core_rstn && rd_pvld && rd_prdy) begin
            check("pop_has_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("pop_data", rd_pd, exp_q.pop_front());
        end
    end

    // RAM addresses must walk 0,1,..,159,0,.. independently on each port.
    always @(negedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            last_wa = DEPTH - 1;
            last_ra = DEPTH - 1;
        end else begin
            if (ram_we) begin
                check("ram_wa_seq", ram_wa, (last_wa == DEPTH - 1) ? 0 : last_wa + 1);
                if (ram_wa == AW'(DEPTH - 1)) wa_wraps++;
                last_wa = ram_wa;
            end
            if (ram_re) begin
                check("ram_ra_seq", ram_ra, (last_ra == DEPTH - 1) ? 0 : last_ra + 1);
                if (ram_ra == AW'(DEPTH - 1)) ra_wraps++;
                last_ra = ram_ra;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_prdy"}, wr_prdy, 0);
        check({tag, "_rd_pvld"}, rd_pvld, 0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_re"}, ram_re, 0);
        check({tag, "_ram_ore"}, ram_ore, 0);
        check({tag, "_ram_wa"}, ram_wa, 0);
        check({tag, "_ram_ra"}, ram_ra, 0);
        check({tag, "_pwrbus"}, ram_pwrbus_pd, pwrbus_ram_pd);
    endtask

    initial begin
        int acc, pops, first, last, hi_cnt, wraps0, seen;
        logic [DW-1:0] data;

        // Reset state and power-bus pass-through while in reset.
        repeat (3) @(posedge nvdla_core_clk);
        #2;
        check_reset_outputs("reset");
        pwrbus_ram_pd = 32'h0F0F_1234;
        #1 check("pwrbus_in_reset", ram_pwrbus_pd, 32'h0F0F_1234);
        pwrbus_ram_pd = 32'hDEADBEEF;
        #1 check("pwrbus_deadbeef", ram_pwrbus_pd, 32'hDEADBEEF);
        nvdla_core_rstn = 1'b1;
        tick();
        @(negedge nvdla_core_clk);
        check("wr_prdy_after_release", wr_prdy, 1);

        // Single word latency: push at t, re at t+1, ore at t+2, rd_pvld at t+4 only.
        tick(); wr_pvld = 1'b1; wr_pd = 16'hA5A5; rd_prdy = 1'b1;
        @(negedge nvdla_core_clk);
        check("t0_ram_we", ram_we, 1);
        check("t0_ram_wa", ram_wa, 0);
        check("t0_ram_di", ram_di, 16'hA5A5);
        tick(); wr_pvld = 1'b0;
        @(negedge nvdla_core_clk);
        check("t1_ram_re", ram_re, 1);
        check("t1_ram_ra", ram_ra, 0);
        tick(); @(negedge nvdla_core_clk);
        check("t2_ram_ore", ram_ore, 1);
        check("t2_ram_re", ram_re, 0);
        tick(); @(negedge nvdla_core_clk);
        check("t3_rd_pvld", rd_pvld, 0);
        tick(); @(negedge nvdla_core_clk);
        check("t4_rd_pvld", rd_pvld, 1);
        check("t4_rd_pd", rd_pd, 16'hA5A5);
        tick(); @(negedge nvdla_core_clk);
        check("t5_rd_pvld", rd_pvld, 0);

        // Fill to 164 with the consumer stalled.
        rd_prdy = 1'b0; acc = 0; data = '0;
        for (int c = 0; c < 400 && acc < TOTAL; c++) begin
            tick(); wr_pvld = 1'b1; wr_pd = data;
            @(negedge nvdla_core_clk);
            if (wr_prdy) begin acc++; data++; end
        end
        check("full_accepts", acc, TOTAL);
        hi_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); @(negedge nvdla_core_clk);
            if (wr_prdy) hi_cnt++;
        end
        check("full_wr_prdy_low", hi_cnt, 0);
        check("full_rd_pvld", rd_pvld, 1);
        check("full_head", rd_pd, 16'h0000);

        // Drain all 164 back-to-back.
        tick(); wr_pvld = 1'b0; rd_prdy = 1'b1;
        pops = 0; first = -1; last = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge nvdla_core_clk);
            if (rd_pvld) begin pops++; if (first < 0) first = c; last = c; end
            tick();
        end
        check("drain_pops", pops, TOTAL);
        check("drain_back_to_back", last - first + 1, TOTAL);
        @(negedge nvdla_core_clk);
        check("drain_empty", rd_pvld, 0);

        // Streaming 1000 words with the consumer always ready.
        wraps0 = ra_wraps; acc = 0; pops = 0; first = -1; last = -1;
        for (int c = 0; c < 5000 && pops < 1000; c++) begin
            tick(); wr_pvld = (acc < 1000); wr_pd = 16'(32'h4000 + acc);
            @(negedge nvdla_core_clk);
            if (wr_pvld && wr_prdy) acc++;
            if (rd_pvld) begin pops++; if (first < 0) first = c; last = c; end
        end
        check("stream_pops", pops, 1000);
        check("stream_no_bubble", last - first + 1, 1000);
        check("stream_ra_wraps", 32'((ra_wraps - wraps0) >= 6), 1);
        check("stream_wa_wraps", 32'(wa_wraps >= 6), 1);

        // Random traffic.
        acc = 0;
        for (int c = 0; c < 40000 && acc < 5000; c++) begin
            tick();
            wr_pvld = 1'($urandom_range(0, 1));
            wr_pd   = 16'($urandom);
            rd_prdy = 1'($urandom_range(0, 1));
            @(negedge nvdla_core_clk);
            if (wr_pvld && wr_prdy) acc++;
        end
        check("random_accepts", acc, 5000);
        tick(); wr_pvld = 1'b0; rd_prdy = 1'b1;
        for (int c = 0; c < 400 && (exp_q.size() != 0 || rd_pvld); c++) tick();
        check("random_drained", exp_q.size(), 0);

        // Reset with entries stored and reads in flight.
        rd_prdy = 1'b0; acc = 0;
        for (int c = 0; c < 200 && acc < 50; c++) begin
            tick(); wr_pvld = 1'b1; wr_pd = 16'(32'hB000 + acc);
            @(negedge nvdla_core_clk);
            if (wr_prdy) acc++;
        end
        tick(); wr_pvld = 1'b0;
        repeat (8) tick();
        rd_prdy = 1'b1;
        tick(); tick();
        #2;
        check("pre_reset_busy", 32'(rd_pvld && ram_re), 1);
        nvdla_core_rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        pwrbus_ram_pd = 32'hCAFE_0001;
        #1 check("pwrbus_midreset", ram_pwrbus_pd, 32'hCAFE_0001);
        repeat (2) tick();
        nvdla_core_rstn = 1'b1;
        tick();
        wr_pvld = 1'b1; wr_pd = 16'h1234;
        @(negedge nvdla_core_clk);
        check("post_reset_accept", wr_prdy, 1);
        tick(); wr_pvld = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge nvdla_core_clk);
            if (rd_pvld) begin
                seen = 1;
                check("post_reset_first_word", rd_pd, 16'h1234);
            end
            tick();
        end
        check("post_reset_output_seen", seen, 1);
        repeat (4) tick();
        check("post_reset_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
